// File: rtl/sal_ref_ctrl.sv
// Refresh request generator for the SAL DDR2 controller: counts tREFI intervals,
// accumulates owed refreshes (up to MAX_PEND), and runs the request/grant/tRFC sequence.
module sal_ref_ctrl #(
   parameter int TREFI_W   = 16,
   parameter int TRFC_W    = 8,
   parameter int MAX_PEND  = 8,
   parameter int URGENT_TH = 6,
   localparam int PEND_W   = $clog2(MAX_PEND + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ref_en_i,
   input  logic [TREFI_W-1:0] trefi_i,
   input  logic [TRFC_W-1:0] trfc_i,
   output logic              ref_req_o,
   input  logic              ref_gnt_i,
   output logic              ref_busy_o,
   output logic              ref_urgent_o,
   output logic [PEND_W-1:0] pend_cnt_o,
   output logic              ref_ovf_o,
   input  logic              ovf_clr_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RFC
   } state_e;

   localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(MAX_PEND);
   localparam logic [PEND_W-1:0]  PEND_ONE = PEND_W'(1);
   localparam logic [PEND_W-1:0]  URG_TH   = PEND_W'(URGENT_TH);
   localparam logic [TREFI_W:0]   INT_ONE  = (TREFI_W + 1)'(1);
   localparam logic [TRFC_W-1:0]  RFC_ONE  = TRFC_W'(1);

   state_e              state_q, state_d;
   logic [TREFI_W-1:0]  int_cnt_q, int_cnt_d;
   logic [TRFC_W-1:0]   busy_cnt_q, busy_cnt_d;
   logic [PEND_W-1:0]   pend_q, pend_d;
   logic                ovf_q, ovf_d;
   logic                req_q, busy_q, urgent_q;

   logic [TREFI_W:0]    int_cnt_inc;
   logic [TRFC_W-1:0]   trfc_load;
   logic                tick;
   logic                gnt_acc;

   // Widened compare so a trefi_i reduced below the running count ticks at once.
   assign int_cnt_inc = {1'b0, int_cnt_q} + INT_ONE;
   assign tick        = ref_en_i && (int_cnt_inc >= {1'b0, trefi_i});
   assign gnt_acc     = (state_q == S_REQ) && ref_gnt_i;
   assign trfc_load   = (trfc_i == '0) ? RFC_ONE : trfc_i;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      int_cnt_d = '0;
      if (ref_en_i && !tick) begin
         int_cnt_d = int_cnt_inc[TREFI_W-1:0];
      end
   end

   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (ovf_clr_i) begin
         ovf_d = 1'b0;
      end
      if (tick && !gnt_acc) begin
         if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + PEND_ONE;
         end
      end else if (gnt_acc && !tick && (pend_q != '0)) begin
         pend_d = pend_q - PEND_ONE;
      end
   end

   always_comb begin
      state_d    = state_q;
      busy_cnt_d = busy_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (pend_d != '0) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (ref_gnt_i) begin
               state_d    = S_RFC;
               busy_cnt_d = trfc_load;
            end
         end
         S_RFC: begin
            if (busy_cnt_q <= RFC_ONE) begin
               busy_cnt_d = '0;
               state_d    = (pend_d != '0) ? S_REQ : S_IDLE;
            end else begin
               busy_cnt_d = busy_cnt_q - RFC_ONE;
            end
         end
         default: begin
            state_d    = S_IDLE;
            busy_cnt_d = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         int_cnt_q  <= '0;
         busy_cnt_q <= '0;
         pend_q     <= '0;
         ovf_q      <= 1'b0;
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
         urgent_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         int_cnt_q  <= int_cnt_d;
         busy_cnt_q <= busy_cnt_d;
         pend_q     <= pend_d;
         ovf_q      <= ovf_d;
         req_q      <= (state_d == S_REQ);
         busy_q     <= (state_d == S_RFC);
         urgent_q   <= (pend_d >= URG_TH);
      end
   end

   assign ref_req_o    = req_q;
   assign ref_busy_o   = busy_q;
   assign ref_urgent_o = urgent_q;
   assign pend_cnt_o   = pend_q;
   assign ref_ovf_o    = ovf_q;

endmodule
